// File: rtl/seg_display_mux.sv
// Time-multiplexed seven-segment bank driver: scans NUM_DIGITS patterns onto one
// shared segment bus with blanking between slots, per-digit masking and PWM brightness.
//
//   state | meaning
//   BLANK | all digits off for BLANK_TICKS cycles before a digit's ON phase
//   ON    | current digit driven for DWELL_TICKS cycles, enable gated by PWM and mask
module seg_display_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int SEG_WIDTH    = 8,
  parameter int DWELL_TICKS  = 163840,
  parameter int BLANK_TICKS  = 500,
  parameter int ACTIVE_LOW   = 1,
  parameter int BRIGHT_WIDTH = 4,
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_DIGITS*SEG_WIDTH-1:0] segValues,
  input  logic [NUM_DIGITS-1:0]           digitMask,
  input  logic [BRIGHT_WIDTH-1:0]         brightness,
  output logic [NUM_DIGITS-1:0]           digitEnable,
  output logic [SEG_WIDTH-1:0]            segments,
  output logic [IDX_W-1:0]                digitIndex,
  output logic                            frameStart
);

  localparam int MAX_TICKS = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  localparam logic             INACT_BIT  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_SLOT  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, ON} state_t;

  // With no blanking interval the scanner never visits BLANK, not even out of reset.
  localparam state_t START_STATE = (BLANK_TICKS > 0) ? BLANK : ON;

  state_t           state;
  logic [CNT_W-1:0] tickCount;
  logic [IDX_W-1:0] slotIdx;
  logic             framePending;

  logic [63:0]           threshold;
  logic [NUM_DIGITS-1:0] onEnable;

  // Full-width product so the top brightness code yields exactly DWELL_TICKS.
  assign threshold = ((64'(brightness) + 64'd1) * 64'(DWELL_TICKS)) >> BRIGHT_WIDTH;

  always_comb begin
    onEnable = {NUM_DIGITS{INACT_BIT}};
    if (digitMask[slotIdx] && (64'(tickCount) < threshold)) begin
      onEnable[slotIdx] = ~INACT_BIT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= START_STATE;
      tickCount    <= '0;
      slotIdx      <= '0;
      framePending <= 1'b0;
      digitEnable  <= {NUM_DIGITS{INACT_BIT}};
      segments     <= {SEG_WIDTH{INACT_BIT}};
      digitIndex   <= '0;
      frameStart   <= 1'b0;
    end else begin
      digitIndex   <= slotIdx;
      frameStart   <= framePending;
      framePending <= 1'b0;
      if (state == BLANK) begin
        digitEnable <= {NUM_DIGITS{INACT_BIT}};
        segments    <= {SEG_WIDTH{INACT_BIT}};
        if (tickCount == BLANK_LAST) begin
          state     <= ON;
          tickCount <= '0;
        end else begin
          tickCount <= tickCount + 1'b1;
        end
      end else begin
        digitEnable <= onEnable;
        segments    <= segValues[slotIdx*SEG_WIDTH +: SEG_WIDTH];
        if (tickCount == DWELL_LAST) begin
          state     <= START_STATE;
          tickCount <= '0;
          if (slotIdx == LAST_SLOT) begin
            slotIdx      <= '0;
            framePending <= 1'b1;
          end else begin
            slotIdx <= slotIdx + 1'b1;
          end
        end else begin
          tickCount <= tickCount + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux: default build plus a no-blank build and an
// active-high build driven from the same inputs.
module tb_seg_display_mux;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] segValues;
  logic [3:0]  digitMask;
  logic [1:0]  brightness;

  logic [3:0] enA, enB, enC;
  logic [7:0] segA, segB, segC;
  logic [1:0] idxA, idxB, idxC;
  logic       fsA, fsB, fsC;

  int nApplied = 0;
  int nMiss    = 0;
  int cyc      = -1;

  logic [7:0] pat [4];

  always #5 clock = ~clock;

  seg_display_mux #(.NUM_DIGITS(4), .SEG_WIDTH(8), .DWELL_TICKS(8), .BLANK_TICKS(2),
                    .ACTIVE_LOW(1), .BRIGHT_WIDTH(2)) dutA (
    .clock(clock), .reset(reset), .segValues(segValues), .digitMask(digitMask),
    .brightness(brightness), .digitEnable(enA), .segments(segA), .digitIndex(idxA),
    .frameStart(fsA));

  seg_display_mux #(.NUM_DIGITS(4), .SEG_WIDTH(8), .DWELL_TICKS(8), .BLANK_TICKS(0),
                    .ACTIVE_LOW(1), .BRIGHT_WIDTH(2)) dutB (
    .clock(clock), .reset(reset), .segValues(segValues), .digitMask(digitMask),
    .brightness(brightness), .digitEnable(enB), .segments(segB), .digitIndex(idxB),
    .frameStart(fsB));

  seg_display_mux #(.NUM_DIGITS(4), .SEG_WIDTH(8), .DWELL_TICKS(8), .BLANK_TICKS(2),
                    .ACTIVE_LOW(0), .BRIGHT_WIDTH(2)) dutC (
    .clock(clock), .reset(reset), .segValues(segValues), .digitMask(digitMask),
    .brightness(brightness), .digitEnable(enC), .segments(segC), .digitIndex(idxC),
    .frameStart(fsC));

  typedef struct {
    int         t;
    logic [1:0] br;
    logic [3:0] mask;
    logic [3:0] en;
    logic [7:0] seg;
    logic [1:0] idx;
    logic       fs;
  } vec_t;

  vec_t vecs [28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock; the no-blank build is checked against its timeline every cycle.
  task automatic advance();
    int slotB;
    @(posedge clock);
    cyc++;
    @(negedge clock);
    slotB = (cyc / 8) % 4;
    chk("segB", 32'(segB), 32'(pat[slotB]));
    chk("idxB", 32'(idxB), 32'(slotB));
    chk("fsB", 32'(fsB), (cyc > 0 && cyc % 32 == 0) ? 32'd1 : 32'd0);
    chk("onehotB", ($countones(~enB) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  function automatic vec_t mk(int t, logic [1:0] br, logic [3:0] mask, logic [3:0] en,
                              logic [7:0] seg, logic [1:0] idx, logic fs);
    vec_t v;
    v.t = t; v.br = br; v.mask = mask; v.en = en; v.seg = seg; v.idx = idx; v.fs = fs;
    return v;
  endfunction

  initial begin
    int pulses;
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;

    vecs[0]  = mk(0,   2'd3, 4'hF, 4'hF, 8'hFF, 2'd0, 1'b0);
    vecs[1]  = mk(1,   2'd3, 4'hF, 4'hF, 8'hFF, 2'd0, 1'b0);
    vecs[2]  = mk(2,   2'd3, 4'hF, 4'hE, 8'h11, 2'd0, 1'b0);
    vecs[3]  = mk(9,   2'd3, 4'hF, 4'hE, 8'h11, 2'd0, 1'b0);
    vecs[4]  = mk(10,  2'd3, 4'hF, 4'hF, 8'hFF, 2'd1, 1'b0);
    vecs[5]  = mk(12,  2'd3, 4'hF, 4'hD, 8'h22, 2'd1, 1'b0);
    vecs[6]  = mk(22,  2'd3, 4'hF, 4'hB, 8'h33, 2'd2, 1'b0);
    vecs[7]  = mk(32,  2'd3, 4'hF, 4'h7, 8'h44, 2'd3, 1'b0);
    vecs[8]  = mk(39,  2'd3, 4'hF, 4'h7, 8'h44, 2'd3, 1'b0);
    vecs[9]  = mk(40,  2'd3, 4'hF, 4'hF, 8'hFF, 2'd0, 1'b1);
    vecs[10] = mk(41,  2'd3, 4'hF, 4'hF, 8'hFF, 2'd0, 1'b0);
    vecs[11] = mk(42,  2'd3, 4'hF, 4'hE, 8'h11, 2'd0, 1'b0);
    vecs[12] = mk(52,  2'd1, 4'hF, 4'hD, 8'h22, 2'd1, 1'b0);
    vecs[13] = mk(55,  2'd1, 4'hF, 4'hD, 8'h22, 2'd1, 1'b0);
    vecs[14] = mk(56,  2'd1, 4'hF, 4'hF, 8'h22, 2'd1, 1'b0);
    vecs[15] = mk(59,  2'd1, 4'hF, 4'hF, 8'h22, 2'd1, 1'b0);
    vecs[16] = mk(63,  2'd0, 4'hF, 4'hB, 8'h33, 2'd2, 1'b0);
    vecs[17] = mk(64,  2'd0, 4'hF, 4'hF, 8'h33, 2'd2, 1'b0);
    vecs[18] = mk(65,  2'd3, 4'hF, 4'hB, 8'h33, 2'd2, 1'b0);
    vecs[19] = mk(80,  2'd3, 4'hB, 4'hF, 8'hFF, 2'd0, 1'b1);
    vecs[20] = mk(82,  2'd3, 4'hB, 4'hE, 8'h11, 2'd0, 1'b0);
    vecs[21] = mk(92,  2'd3, 4'hB, 4'hD, 8'h22, 2'd1, 1'b0);
    vecs[22] = mk(102, 2'd3, 4'hB, 4'hF, 8'h33, 2'd2, 1'b0);
    vecs[23] = mk(109, 2'd3, 4'hB, 4'hF, 8'h33, 2'd2, 1'b0);
    vecs[24] = mk(112, 2'd3, 4'hB, 4'h7, 8'h44, 2'd3, 1'b0);
    vecs[25] = mk(120, 2'd3, 4'hB, 4'hF, 8'hFF, 2'd0, 1'b1);
    vecs[26] = mk(129, 2'd3, 4'hB, 4'hE, 8'h11, 2'd0, 1'b0);
    vecs[27] = mk(132, 2'd3, 4'hB, 4'hD, 8'h22, 2'd1, 1'b0);

    segValues  = 32'h4433_2211;
    digitMask  = 4'hF;
    brightness = 2'd3;
    reset      = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rstA.en",  32'(enA),  32'hF);
    chk("rstA.seg", 32'(segA), 32'hFF);
    chk("rstA.idx", 32'(idxA), 32'd0);
    chk("rstA.fs",  32'(fsA),  32'd0);
    chk("rstB.en",  32'(enB),  32'hF);
    chk("rstC.en",  32'(enC),  32'h0);
    chk("rstC.seg", 32'(segC), 32'h00);
    reset = 1'b0;
    cyc   = -1;

    foreach (vecs[k]) begin
      brightness = vecs[k].br;
      digitMask  = vecs[k].mask;
      while (cyc < vecs[k].t) advance();
      chk($sformatf("v%0d.en",  k), 32'(enA),  32'(vecs[k].en));
      chk($sformatf("v%0d.seg", k), 32'(segA), 32'(vecs[k].seg));
      chk($sformatf("v%0d.idx", k), 32'(idxA), 32'(vecs[k].idx));
      chk($sformatf("v%0d.fs",  k), 32'(fsA),  32'(vecs[k].fs));
    end

    // Single-cycle reset while digit 2 is at dwellCount 5.
    digitMask  = 4'hF;
    brightness = 2'd3;
    while (cyc < 147) advance();
    chk("preRst.en",  32'(enA),  32'hB);
    chk("preRst.seg", 32'(segA), 32'h33);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("midRstA.en",  32'(enA),  32'hF);
    chk("midRstA.seg", 32'(segA), 32'hFF);
    chk("midRstA.idx", 32'(idxA), 32'd0);
    chk("midRstA.fs",  32'(fsA),  32'd0);
    chk("midRstB.en",  32'(enB),  32'hF);
    chk("midRstC.en",  32'(enC),  32'h0);
    reset = 1'b0;
    cyc   = -1;

    advance();
    chk("restartA.en",  32'(enA),  32'hF);
    chk("restartA.idx", 32'(idxA), 32'd0);
    chk("restartB.en",  32'(enB),  32'hE);
    chk("restartC.en",  32'(enC),  32'h0);
    chk("restartC.seg", 32'(segC), 32'h00);
    advance();
    advance();
    chk("restartA.on.en",  32'(enA),  32'hE);
    chk("restartA.on.seg", 32'(segA), 32'h11);
    chk("restartC.on.en",  32'(enC),  32'h1);
    chk("restartC.on.seg", 32'(segC), 32'h11);
    chk("restartC.on.idx", 32'(idxC), 32'd0);

    pulses = 0;
    while (cyc < 39) begin
      advance();
      if (fsA) pulses++;
    end
    chk("noFrameAfterReset", 32'(pulses), 32'd0);
    advance();
    chk("frameA.t40", 32'(fsA), 32'd1);
    chk("frameC.t40", 32'(fsC), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
Parametrised time-multiplexed driver for a common-anode or common-cathode seven-segment bank. It accepts N pre-decoded segment patterns and scans them onto one shared segment bus with one-hot digit enables. Over the fixed 4-digit scanner, it adds:
- configurable digit count, dwell and polarity;
- an inter-digit blanking interval (anti-ghosting);
- a per-digit enable mask;
- PWM brightness.

It sits between display-formatting logic and the board pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=1)
SEG_WIDTH, 8, bits per pre-decoded pattern (7 segments + DP)
DWELL_TICKS, 163840, clock cycles each digit slot is in ON phase (>=1)
BLANK_TICKS, 500, clock cycles of all-off before each digit's ON phase (>=0)
ACTIVE_LOW, 1, 1 = enables and segments active-low; 0 = active-high
BRIGHT_WIDTH, 4, width of brightness input

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
segValues  in  NUM_DIGITS*SEG_WIDTH  digit i pattern at [i*SEG_WIDTH +: SEG_WIDTH], already in board polarity
digitMask  in  NUM_DIGITS  1 = digit i shown, 0 = slot kept but dark
brightness  in  BRIGHT_WIDTH  PWM duty select
digitEnable  out  NUM_DIGITS  one-hot (in active polarity) digit enables
segments  out  SEG_WIDTH  shared segment bus
digitIndex  out  clog2(NUM_DIGITS) (min 1)  slot currently being scanned
frameStart  out  1  one-cycle pulse at start of each new frame

Behaviour:
- One clock domain. Reset is synchronous and active-high: `reset` is sampled on the rising edge of `clock`.
- Definitions:
  - INACT = all ones if ACTIVE_LOW, else all zeros.
  - BLANKSEG = INACT at SEG_WIDTH.
  - Enable "active" means the inverse of INACT for that bit.
- All outputs are registered.
- Reset values, which also apply at the edge after reset is asserted mid-operation, with no partial completion of the current slot:
  - digitEnable = INACT (no digit lit);
  - segments = BLANKSEG;
  - digitIndex = 0;
  - frameStart = 0;
  - FSM state = BLANK, tick counter = 0.
- FSM states:
  - BLANK:
    - Outputs: digitEnable = INACT, segments = BLANKSEG.
    - Lasts exactly BLANK_TICKS cycles, then goes to ON.
    - If BLANK_TICKS = 0, BLANK is skipped entirely and ON follows ON directly.
  - ON:
    - Lasts exactly DWELL_TICKS cycles, counted by dwellCount 0..DWELL_TICKS-1.
    - segments = slice digitIndex of segValues, sampled every cycle. An input change is visible one cycle later.
    - digitEnable bit digitIndex is active iff digitMask[digitIndex]=1 and dwellCount < threshold. All other enable bits are INACT.
    - threshold = ((brightness+1)*DWELL_TICKS) >> BRIGHT_WIDTH, computed at full width with no overflow. Maximum brightness gives the full dwell.
    - brightness and digitMask are re-evaluated every cycle; changes take effect on the next cycle with no glitch beyond the normal one-cycle latency.
- End of ON:
  - digitIndex increments, wrapping from NUM_DIGITS-1 to 0; the next state is BLANK (or ON if BLANK_TICKS=0).
  - On the wrap only, frameStart = 1 for exactly one cycle, coincident with the first cycle of digit 0's BLANK (or ON).
  - No frameStart pulse is produced out of reset.
- Masked-off digits keep their full BLANK+DWELL slot, so the frame period is constant: NUM_DIGITS*(BLANK_TICKS+DWELL_TICKS) cycles.
- Invariant: at most one digitEnable bit is ever active; no two digits are lit in the same cycle.
- Timeline out of reset: with the first non-reset edge at cycle 0, outputs show BLANK for cycles 0..BLANK_TICKS-1, then digit 0 ON for DWELL_TICKS cycles, then the sequence repeats per slot.
- Tick counter width: clog2(max(DWELL_TICKS,BLANK_TICKS)+1). It resets to 0 on every state change.

Test Plan:
Common setup: NUM_DIGITS=4, DWELL_TICKS=8, BLANK_TICKS=2, BRIGHT_WIDTH=2, ACTIVE_LOW=1 unless stated. Thresholds are brightness 0..3 -> 2,4,6,8.

1. Reset and scan: hold reset 3 cycles; segValues={0x44,0x33,0x22,0x11}; mask=4'b1111; brightness=3 -> required response:
   - during reset: digitEnable=4'b1111, segments=0xFF;
   - then 2 cycles blank;
   - then 8 cycles of 4'b1110/0x11, 2 blank, 8 cycles of 4'b1101/0x22, and so on;
   - frameStart pulses once every 40 cycles, first at cycle 40.
2. Brightness=1 -> in each ON slot the digit enable is active for dwellCount 0..3 and inactive for 4..7; segments hold the digit pattern all 8 cycles. Brightness=0 -> 2 active cycles per slot.
3. digitMask=4'b1011 -> the digit 2 slot keeps digitEnable=4'b1111 for its 10 cycles; frame period stays 40; digits 0, 1 and 3 are unaffected.
4. BLANK_TICKS=0 build -> ON slots are back-to-back; frame period is 32; assert that popcount(~digitEnable) ≤ 1 every cycle.
5. Assert reset for 1 cycle at dwellCount=5 of digit 2 -> the next edge shows reset values; the scan restarts at digit 0 BLANK; no frameStart is emitted.
6. ACTIVE_LOW=0 build -> reset gives digitEnable=4'b0000 and segments=0x00; digit 0 ON shows digitEnable=4'b0001.
